button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 270000, setting the consecutive sys_clk cycles an input must hold a new level before it is accepted (10 ms at 27 MHz; legal range >= 1).
REQ-002 The block SHALL have parameter MODE_RESET, default 1'b0, setting the value loaded into mode on reset.
REQ-003 The block SHALL have port sys_clk  input  1  system clock; the single clock domain, all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port key_n  input  1  raw mode-select push-button; asynchronous, active-low, bouncing.
REQ-006 The block SHALL have port step_n  input  1  raw manual-step push-button; asynchronous, active-low, bouncing.
REQ-007 The block SHALL have port mode  output  1  clock-mode level: 0 = manual step, 1 = free-running; feeds the clock block's mode input.
REQ-008 The block SHALL have port button  output  1  debounced step-button level, 1 = pressed; feeds the clock block's button input.
REQ-009 The block SHALL have port step_pulse  output  1  single-cycle strobe on each accepted step-button press.
REQ-010 The block SHALL have port key_pulse  output  1  single-cycle strobe on each accepted mode-button press.

Function
REQ-011 Each raw input SHALL be inverted to active-high and passed through a two-flop synchronizer before any other use.
REQ-012 Each input SHALL have an independent debouncer holding a stable level and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 On any cycle where the synchronized sample equals the stable level, that counter SHALL clear to 0.
REQ-014 On a mismatching cycle with counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1; it SHALL never wrap.
REQ-015 On a mismatching cycle with counter = DEBOUNCE_CYCLES-1, the stable level SHALL flip and the counter SHALL clear to 0.
REQ-016 Latency: with the raw input held at a new level and edge 1 the first edge sampling it, the stable level SHALL change on edge DEBOUNCE_CYCLES+2.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL change no output.
REQ-018 button SHALL equal the step debouncer's stable level, registered, with no additional delay.
REQ-019 step_pulse SHALL be 1 for exactly the cycle following the edge on which the step stable level flips 0->1; it SHALL be 0 on release and at all other times.
REQ-020 key_pulse SHALL follow the same rule as REQ-019 for the mode debouncer.
REQ-021 mode SHALL toggle on the same edge that key_pulse rises; a held mode button SHALL toggle mode exactly once.
REQ-022 The two debouncers SHALL operate independently; simultaneous presses SHALL each produce their own pulse in the same cycle.
REQ-023 Pulses SHALL never exceed one cycle; consecutive pulses SHALL be separated by at least 2*DEBOUNCE_CYCLES cycles.

Reset
REQ-024 While rst = 1 at a rising edge, synchronizer flops, stable levels, counters, button, step_pulse and key_pulse SHALL load 0, and mode SHALL load MODE_RESET.
REQ-025 Reset SHALL override all in-flight counting; a button held through reset SHALL be treated as a new press after release and produce a pulse DEBOUNCE_CYCLES+2 edges after the first edge with rst = 0.
REQ-026 No output SHALL change asynchronously to sys_clk.

Verification (DEBOUNCE_CYCLES = 4, MODE_RESET = 0)
REQ-027 Bench SHALL check reset: rst held 3 cycles with both inputs pressed -> mode = 0, button = 0, both pulses = 0 throughout reset.
REQ-028 Bench SHALL check a clean press: step_n driven 1->0 and held -> button = 1 from edge 6 onward, step_pulse = 1 for exactly one cycle, mode unchanged.
REQ-029 Bench SHALL check bounce rejection: step_n toggled with 3-cycle low periods separated by 1-cycle highs, then held low -> exactly one step_pulse, issued 6 edges after the final falling transition.
REQ-030 Bench SHALL check the mode toggle: two separated clean presses of key_n, each held for 20 cycles -> mode goes 0->1->0, two key_pulse strobes, button stays 0.
REQ-031 Bench SHALL check simultaneous presses: key_n and step_n fall on the same cycle -> key_pulse and step_pulse assert in the same cycle and mode toggles.
REQ-032 Bench SHALL check a mid-count reset: rst asserted when the step counter = 2 -> counter cleared, no pulse during reset, and a single pulse 6 edges after rst deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces the raw mode-select and
// manual-step push-buttons, producing a debounced step level, single-cycle
// press strobes for both buttons, and a mode level toggled by each mode press.
//
// Handshake note: this block has no valid/ready interfaces; the pulse
// outputs are plain one-cycle strobes with no back-pressure.
//
// Internally each per-button signal is a 2-bit vector:
//   bit 0 = step button, bit 1 = mode (key) button.
module button_conditioner #(
  parameter int   DEBOUNCE_CYCLES = 270000,
  parameter logic MODE_RESET      = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_n,
  input  logic step_n,
  output logic mode,
  output logic button,
  output logic step_pulse,
  output logic key_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Last count before the stable level may flip. Using DEBOUNCE_CYCLES-1 gives
  // a flip on edge DEBOUNCE_CYCLES+2 after the raw edge: two edges in the
  // synchronizer, then DEBOUNCE_CYCLES mismatching cycles.
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam int STEP = 0;
  localparam int KEY  = 1;

  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    pulse_q, pulse_d;
  logic          mode_q, mode_d;

  // Buttons are active-low; convert to active-high before synchronizing.
  assign raw = {~key_n, ~step_n};

  // Synchronizer chain, debouncer counters and press detection.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    pulse_d  = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        // Input agrees with the accepted level: any partial count is a glitch.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // Held long enough: accept the new level. A 0->1 flip is a press.
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
        pulse_d[i]  = ~stable_q[i];
      end else begin
        // Saturates at CNT_MAX by construction, so it never wraps.
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // Mode toggles on the same edge that raises key_pulse.
    mode_d = mode_q ^ pulse_d[KEY];
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      pulse_q  <= '0;
      mode_q   <= MODE_RESET;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      pulse_q  <= pulse_d;
      mode_q   <= mode_d;
    end
  end

  assign button     = stable_q[STEP];
  assign step_pulse = pulse_q[STEP];
  assign key_pulse  = pulse_q[KEY];
  assign mode       = mode_q;

endmodule
